// File: rtl/l2_cache.sv
// l2_cache: write-back, write-allocate 128-bit line cache between one L1 and memory.
// Define L2_TWO_WAY_EN for a 2-way LRU build; direct-mapped when undefined.
module l2_cache #(
  parameter int SETS  = 64,
  parameter int IDX_W = 6
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [27:0]  proc_addr,
  input  logic [127:0] proc_wdata,
  output logic [127:0] proc_rdata,
  output logic         proc_ready,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);
  localparam int TAG_W = 28 - IDX_W;
  localparam int LOC_W = IDX_W + 1;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RESP = 3'd1;
  localparam logic [2:0] WB   = 3'd2;
  localparam logic [2:0] GAP  = 3'd3;
  localparam logic [2:0] FILL = 3'd4;

  logic [2:0]   state_q, state_d;
  logic         way_q, way_d;
  logic [127:0] rdata_q, rdata_d;
  logic [27:0]  maddr_q, maddr_d;
  logic [127:0] mwdata_q, mwdata_d;

  // Storage location is {way, index}; the direct-mapped build only uses way 0.
  logic [2*SETS-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0]  tag_mem  [2*SETS];
  logic [127:0]      line_mem [2*SETS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             req;
  logic [LOC_W-1:0] loc0, hloc, vloc, wloc, aloc;
  logic             hit0, hit1, hit, hit_way, vic_way;
  logic             arr_we, arr_dirty, arr_way, clr_dirty;
  logic [127:0]     arr_data;

  assign idx  = proc_addr[IDX_W-1:0];
  assign tag  = proc_addr[27:IDX_W];
  assign req  = proc_read | proc_write;
  assign loc0 = {1'b0, idx};
  assign hit0 = valid_q[loc0] && tag_mem[loc0] == tag;

`ifdef L2_TWO_WAY_EN
  logic [LOC_W-1:0] loc1;
  logic [SETS-1:0]  lru_q;

  assign loc1    = {1'b1, idx};
  assign hit1    = valid_q[loc1] && tag_mem[loc1] == tag;
  assign vic_way = !valid_q[loc0] ? 1'b0 :
                   !valid_q[loc1] ? 1'b1 : lru_q[idx];

  // lru_q holds the way to victimize next in each set.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      lru_q <= '0;
    end else if (arr_we) begin
      lru_q[idx] <= ~arr_way;
    end else if (state_q == IDLE && req && hit) begin
      lru_q[idx] <= ~hit_way;
    end
  end
`else
  assign hit1    = 1'b0;
  assign vic_way = 1'b0;
`endif

  assign hit     = hit0 | hit1;
  assign hit_way = hit1;
  assign hloc    = {hit_way, idx};
  assign vloc    = {vic_way, idx};
  assign wloc    = {way_q, idx};
  assign aloc    = {arr_way, idx};

  always_comb begin
    state_d   = state_q;
    way_d     = way_q;
    rdata_d   = rdata_q;
    maddr_d   = maddr_q;
    mwdata_d  = mwdata_q;
    arr_we    = 1'b0;
    arr_way   = way_q;
    arr_data  = proc_wdata;
    arr_dirty = 1'b1;
    clr_dirty = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            way_d   = hit_way;
            arr_way = hit_way;
            if (proc_read) rdata_d = line_mem[hloc];
            else           arr_we  = 1'b1;
            state_d = RESP;
          end else begin
            way_d   = vic_way;
            arr_way = vic_way;
            if (valid_q[vloc] && dirty_q[vloc]) begin
              maddr_d  = {tag_mem[vloc], idx};
              mwdata_d = line_mem[vloc];
              state_d  = WB;
            end else if (proc_read) begin
              maddr_d = proc_addr;
              state_d = FILL;
            end else begin
              arr_we  = 1'b1;
              state_d = RESP;
            end
          end
        end
      end
      WB: begin
        if (mem_ready) begin
          clr_dirty = 1'b1;
          if (proc_read) begin
            maddr_d = proc_addr;
            state_d = GAP;
          end else begin
            arr_we  = 1'b1;
            state_d = RESP;
          end
        end
      end
      GAP: state_d = FILL;
      FILL: begin
        if (mem_ready) begin
          arr_we    = 1'b1;
          arr_data  = mem_rdata;
          arr_dirty = 1'b0;
          rdata_d   = mem_rdata;
          state_d   = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q  <= IDLE;
      way_q    <= 1'b0;
      rdata_q  <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
    end else begin
      state_q  <= state_d;
      way_q    <= way_d;
      rdata_q  <= rdata_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      if (clr_dirty) dirty_q[wloc] <= 1'b0;
      if (arr_we) begin
        valid_q[aloc] <= 1'b1;
        dirty_q[aloc] <= arr_dirty;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!proc_reset && arr_we) begin
      tag_mem[aloc]  <= tag;
      line_mem[aloc] <= arr_data;
    end
  end

  assign proc_ready = (state_q == RESP);
  assign mem_read   = (state_q == FILL);
  assign mem_write  = (state_q == WB);
  assign proc_rdata = rdata_q;
  assign mem_addr   = maddr_q;
  assign mem_wdata  = mwdata_q;
endmodule

// File: tb/tb_l2_cache.sv
// tb_l2_cache: randomized and directed checks of l2_cache against a
// recency-list cache model and a behavioural memory responder.
module tb_l2_cache;
  localparam int SETS  = 64;
  localparam int IDX_W = 6;
`ifdef L2_TWO_WAY_EN
  localparam int WAYS = 2;
`else
  localparam int WAYS = 1;
`endif

  logic         clk = 1'b0;
  logic         proc_reset = 1'b0;
  logic         proc_read = 1'b0;
  logic         proc_write = 1'b0;
  logic [27:0]  proc_addr = '0;
  logic [127:0] proc_wdata = '0;
  logic [127:0] proc_rdata;
  logic         proc_ready;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;

  always #5 clk = ~clk;

  l2_cache #(.SETS(SETS), .IDX_W(IDX_W)) dut (
    .clk(clk), .proc_reset(proc_reset),
    .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_rdata(proc_rdata), .proc_ready(proc_ready),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] mem_arr [logic [27:0]];

  // Model: per set, a list of resident lines, most recently used first.
  int           m_cnt   [SETS];
  logic [27:0]  m_addr  [SETS][2];
  logic [127:0] m_data  [SETS][2];
  bit           m_dirty [SETS][2];

  bit           e_hit, e_wb;
  logic [27:0]  e_wa;
  logic [127:0] e_wd, e_rd;

  int           o_nrd, o_nwr, o_cyc, o_gap;
  bit           o_to, o_bad;
  logic [27:0]  o_wa, o_ra;
  logic [127:0] o_wd, o_rdata;

  function automatic logic [127:0] init_line(input logic [27:0] a);
    return {4{a, 4'h5}};
  endfunction

  function automatic logic [127:0] mem_get(input logic [27:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return init_line(a);
  endfunction

  function automatic int lat(input bit wr, input int d1, input int d2);
    int c = 2;
    if (!e_hit && e_wb) c += d1;
    if (!e_hit && !wr) c += d2 + (e_wb ? 1 : 0);
    return c;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) m_cnt[s] = 0;
  endtask

  task automatic model_op(input bit wr, input logic [27:0] a,
                          input logic [127:0] wd);
    int s = int'(a % SETS);
    int p = -1;
    logic [127:0] d;
    bit dy;
    e_wb = 0; e_wa = '0; e_wd = '0;
    for (int i = 0; i < m_cnt[s]; i++)
      if (m_addr[s][i] == a) p = i;
    if (p >= 0) begin
      e_hit = 1;
      d  = wr ? wd : m_data[s][p];
      dy = wr ? 1'b1 : m_dirty[s][p];
      for (int i = p; i > 0; i--) begin
        m_addr[s][i] = m_addr[s][i-1];
        m_data[s][i] = m_data[s][i-1];
        m_dirty[s][i] = m_dirty[s][i-1];
      end
    end else begin
      e_hit = 0;
      if (m_cnt[s] == WAYS) begin
        if (m_dirty[s][WAYS-1]) begin
          e_wb = 1;
          e_wa = m_addr[s][WAYS-1];
          e_wd = m_data[s][WAYS-1];
        end
        m_cnt[s]--;
      end
      d  = wr ? wd : mem_get(a);
      dy = wr;
      for (int i = m_cnt[s]; i > 0; i--) begin
        m_addr[s][i] = m_addr[s][i-1];
        m_data[s][i] = m_data[s][i-1];
        m_dirty[s][i] = m_dirty[s][i-1];
      end
      m_cnt[s]++;
    end
    m_addr[s][0] = a;
    m_data[s][0] = d;
    m_dirty[s][0] = dy;
    e_rd = d;
  endtask

  // Drives one L1 request and plays memory with delays d1 (write) / d2 (read).
  task automatic run_op(input bit wr, input logic [27:0] a,
                        input logic [127:0] wd, input int d1, input int d2);
    int w = 0;
    logic [27:0]  hold_a = '0;
    logic [127:0] hold_d = '0;
    o_nrd = 0; o_nwr = 0; o_cyc = 0; o_gap = 0; o_to = 0; o_bad = 0;
    o_wa = '0; o_wd = '0; o_ra = '0; o_rdata = '0;
    proc_addr = a; proc_wdata = wd;
    proc_read = !wr; proc_write = wr;
    forever begin
      @(negedge clk);
      o_cyc++;
      if (proc_ready) begin
        o_rdata = proc_rdata;
        break;
      end
      if (o_cyc > 300) begin
        o_to = 1;
        break;
      end
      if (mem_read && mem_write) o_bad = 1;
      if (mem_read || mem_write) begin
        if (w == 0) begin
          hold_a = mem_addr;
          hold_d = mem_wdata;
        end else if (mem_addr !== hold_a ||
                     (mem_write && mem_wdata !== hold_d)) begin
          o_bad = 1;
        end
        w++;
        if (w == (mem_write ? d1 : d2)) begin
          mem_ready = 1'b1;
          if (mem_write) begin
            o_nwr++;
            o_wa = mem_addr;
            o_wd = mem_wdata;
            mem_arr[mem_addr] = mem_wdata;
          end else begin
            o_nrd++;
            o_ra = mem_addr;
            mem_rdata = mem_get(mem_addr);
          end
        end
      end else if (o_nwr > 0 && o_nrd == 0) begin
        o_gap++;
      end
      @(posedge clk);
      #1;
      if (mem_ready) begin
        mem_ready = 1'b0;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        w = 0;
      end
    end
    @(posedge clk);
    #1;
    proc_read = 1'b0;
    proc_write = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    proc_reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (proc_ready !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl got rdy=%b mr=%b mw=%b exp 0 0 0",
               proc_ready, mem_read, mem_write);
    end
    n_tests++;
    if (proc_rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_data got rdata=%h addr=%h wdata=%h exp 0",
               proc_rdata, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    proc_reset = 1'b0;
    model_clear();
  endtask

  task automatic test_cold_miss();
    logic [127:0] a5 = {16{8'hA5}};
    mem_arr[28'h0000010] = a5;
    model_op(0, 28'h0000010, '0);
    run_op(0, 28'h0000010, '0, 1, 3);
    n_tests++;
    if (o_nrd !== 1 || o_nwr !== 0 || o_ra !== 28'h0000010) begin
      n_fail++;
      $display("FAIL cold_mem got nrd=%0d nwr=%0d ra=%h exp 1 0 0000010",
               o_nrd, o_nwr, o_ra);
    end
    n_tests++;
    if (o_rdata !== a5 || o_cyc !== 5 || o_to) begin
      n_fail++;
      $display("FAIL cold_data got rdata=%h cyc=%0d exp %h 5", o_rdata, o_cyc, a5);
    end
    model_op(0, 28'h0000010, '0);
    run_op(0, 28'h0000010, '0, 1, 3);
    n_tests++;
    if (o_nrd !== 0 || o_nwr !== 0 || o_cyc !== 2 || o_rdata !== a5) begin
      n_fail++;
      $display("FAIL cold_rehit got nrd=%0d nwr=%0d cyc=%0d rdata=%h exp 0 0 2 %h",
               o_nrd, o_nwr, o_cyc, o_rdata, a5);
    end
  endtask

  task automatic test_write_hit();
    model_op(1, 28'h0000010, 128'h1234);
    run_op(1, 28'h0000010, 128'h1234, 1, 1);
    n_tests++;
    if (o_nrd !== 0 || o_nwr !== 0 || o_cyc !== 2) begin
      n_fail++;
      $display("FAIL whit_write got nrd=%0d nwr=%0d cyc=%0d exp 0 0 2",
               o_nrd, o_nwr, o_cyc);
    end
    model_op(0, 28'h0000010, '0);
    run_op(0, 28'h0000010, '0, 1, 1);
    n_tests++;
    if (o_rdata !== 128'h1234 || o_cyc !== 2 || o_nrd !== 0) begin
      n_fail++;
      $display("FAIL whit_read got rdata=%h cyc=%0d exp 1234 2", o_rdata, o_cyc);
    end
  endtask

  task automatic test_dirty_evict();
    model_op(0, 28'h0000050, '0);
    run_op(0, 28'h0000050, '0, 2, 2);
    n_tests++;
    if (o_nwr !== (e_wb ? 1 : 0) || (e_wb && (o_wa !== e_wa || o_wd !== e_wd))) begin
      n_fail++;
      $display("FAIL evict_wb got nwr=%0d wa=%h wd=%h exp wb=%0d %h %h",
               o_nwr, o_wa, o_wd, e_wb, e_wa, e_wd);
    end
`ifndef L2_TWO_WAY_EN
    n_tests++;
    if (o_wa !== 28'h0000010 || o_wd !== 128'h1234 || o_gap !== 1) begin
      n_fail++;
      $display("FAIL evict_dm got wa=%h wd=%h gap=%0d exp 0000010 1234 1",
               o_wa, o_wd, o_gap);
    end
`endif
    n_tests++;
    if (o_nrd !== 1 || o_ra !== 28'h0000050 || o_rdata !== e_rd ||
        o_cyc !== lat(0, 2, 2) || o_bad) begin
      n_fail++;
      $display("FAIL evict_fill got nrd=%0d ra=%h rdata=%h cyc=%0d bad=%0d exp 1 0000050 %h %0d 0",
               o_nrd, o_ra, o_rdata, o_cyc, o_bad, e_rd, lat(0, 2, 2));
    end
  endtask

  task automatic test_write_miss();
    bit seen = 0;
    logic [27:0] rd_seq [2];
    rd_seq[0] = 28'h0000063;
    rd_seq[1] = 28'h00000A3;
    model_op(1, 28'h0000023, 128'hFF);
    run_op(1, 28'h0000023, 128'hFF, 1, 1);
    n_tests++;
    if (o_nrd !== 0 || o_nwr !== 0 || o_cyc !== 2) begin
      n_fail++;
      $display("FAIL wmiss_install got nrd=%0d nwr=%0d cyc=%0d exp 0 0 2",
               o_nrd, o_nwr, o_cyc);
    end
    for (int k = 0; k < 2; k++) begin
      model_op(0, rd_seq[k], '0);
      run_op(0, rd_seq[k], '0, 3, 1);
      if (o_nwr == 1 && o_wa === 28'h0000023 && o_wd === 128'hFF) seen = 1;
      n_tests++;
      if (o_rdata !== e_rd || o_cyc !== lat(0, 3, 1)) begin
        n_fail++;
        $display("FAIL wmiss_read%0d got rdata=%h cyc=%0d exp %h %0d",
                 k, o_rdata, o_cyc, e_rd, lat(0, 3, 1));
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL wmiss_wb got seen=0 exp writeback of 0000023 with FF");
    end
  endtask

  task automatic test_two_way();
    logic [27:0] seq [6];
    int nrd_a = -1, nrd_b = -1;
    seq[0] = 28'h0; seq[1] = 28'h40; seq[2] = 28'h0;
    seq[3] = 28'h80; seq[4] = 28'h0; seq[5] = 28'h40;
    for (int k = 0; k < 6; k++) begin
      model_op(0, seq[k], '0);
      run_op(0, seq[k], '0, 2, 2);
      if (k == 4) nrd_a = o_nrd;
      if (k == 5) nrd_b = o_nrd;
      n_tests++;
      if (o_nrd !== (e_hit ? 0 : 1) || o_rdata !== e_rd) begin
        n_fail++;
        $display("FAIL assoc_step%0d got nrd=%0d rdata=%h exp %0d %h",
                 k, o_nrd, o_rdata, e_hit ? 0 : 1, e_rd);
      end
    end
    n_tests++;
`ifdef L2_TWO_WAY_EN
    if (nrd_a !== 0 || nrd_b !== 1) begin
      n_fail++;
      $display("FAIL assoc_lru got a_nrd=%0d b_nrd=%0d exp 0 1", nrd_a, nrd_b);
    end
`else
    if (nrd_a !== 1 || nrd_b !== 1) begin
      n_fail++;
      $display("FAIL assoc_dm got a_nrd=%0d b_nrd=%0d exp 1 1", nrd_a, nrd_b);
    end
`endif
  endtask

  task automatic test_random();
    logic [27:0]  a;
    logic [127:0] wd;
    bit           wr;
    int           d1, d2;
    for (int k = 0; k < 200; k++) begin
      a  = 28'($urandom_range(0, 5) * 64 + $urandom_range(0, 3));
      wr = ($urandom_range(0, 9) < 4);
      wd = {$urandom, $urandom, $urandom, $urandom};
      d1 = $urandom_range(1, 4);
      d2 = $urandom_range(1, 4);
      model_op(wr, a, wd);
      run_op(wr, a, wd, d1, d2);
      n_tests++;
      if (o_to || o_bad || o_cyc !== lat(wr, d1, d2)) begin
        n_fail++;
        $display("FAIL rand_timing op=%0d a=%h wr=%0d got cyc=%0d to=%0d bad=%0d exp cyc=%0d",
                 k, a, wr, o_cyc, o_to, o_bad, lat(wr, d1, d2));
      end
      n_tests++;
      if (o_nrd !== ((!e_hit && !wr) ? 1 : 0) || o_nwr !== (e_wb ? 1 : 0) ||
          (o_nrd == 1 && o_ra !== a)) begin
        n_fail++;
        $display("FAIL rand_traffic op=%0d a=%h got nrd=%0d nwr=%0d ra=%h exp hit=%0d wb=%0d",
                 k, a, o_nrd, o_nwr, o_ra, e_hit, e_wb);
      end
      if (e_wb) begin
        n_tests++;
        if (o_wa !== e_wa || o_wd !== e_wd || (!wr && o_gap !== 1)) begin
          n_fail++;
          $display("FAIL rand_wb op=%0d got wa=%h wd=%h gap=%0d exp %h %h",
                   k, o_wa, o_wd, o_gap, e_wa, e_wd);
        end
      end
      if (!wr) begin
        n_tests++;
        if (o_rdata !== e_rd) begin
          n_fail++;
          $display("FAIL rand_rdata op=%0d a=%h got %h exp %h", k, a, o_rdata, e_rd);
        end
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    int n = 0;
    proc_addr = 28'h00003C5;
    proc_wdata = '0;
    proc_read = 1'b1;
    while (!mem_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (!mem_read) begin
      n_fail++;
      $display("FAIL midfill_start got mem_read=%b exp 1", mem_read);
    end
    @(posedge clk); #1;
    proc_reset = 1'b1;
    proc_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (mem_read !== 1'b0 || proc_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midfill_drop got mem_read=%b rdy=%b exp 0 0", mem_read, proc_ready);
    end
    @(posedge clk); #1;
    proc_reset = 1'b0;
    model_clear();
    model_op(0, 28'h00003C5, '0);
    run_op(0, 28'h00003C5, '0, 1, 2);
    n_tests++;
    if (o_nrd !== 1 || o_rdata !== init_line(28'h00003C5)) begin
      n_fail++;
      $display("FAIL midfill_remiss got nrd=%0d rdata=%h exp 1 %h",
               o_nrd, o_rdata, init_line(28'h00003C5));
    end
    model_op(0, 28'h0000000, '0);
    run_op(0, 28'h0000000, '0, 1, 2);
    n_tests++;
    if (o_nrd !== 1 || o_nwr !== 0 || o_rdata !== e_rd) begin
      n_fail++;
      $display("FAIL reset_dirty got nrd=%0d nwr=%0d rdata=%h exp 1 0 %h",
               o_nrd, o_nwr, o_rdata, e_rd);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_write_hit();
    test_dirty_evict();
    test_write_miss();
    test_two_way();
    test_random();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
